sram_io_bridge: RTL and testbench
=================================

# sram_io_bridge

Parametrised memory/IO bridge between the SLC-3 CPU's MAR/MDR side and the external asynchronous 1Mx16 SRAM.
- Runs a multi-cycle SRAM read or write state machine with a configurable number of wait states.
- Drives byte-lane strobes from CPU byte enables.
- Decodes one memory-mapped IO address for board switches and a hex-digit display register.
- Replaces the fixed single-cycle memory subsystem. A req/ready handshake lets the ISDU stall on slow memory.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width; cpu_addr and ADDR share this width.
- WAIT_STATES, 1, extra cycles each SRAM strobe is held; legal range 0..15.
- NUM_HEX, 4, number of 4-bit hex digits in the display register; legal range 1..8.
- IO_ADDR, 20'h0FFFF, memory-mapped IO address (switches on read, hex register on write).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  2  byte enables; [1] upper byte, [0] lower byte; writes only.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid while cpu_ready = 1, held afterwards.
- cpu_ready  out  1  one-cycle completion pulse.
- Switches  in  16  board switches.
- hex_digits  out  4*NUM_HEX  display register; digit 0 is bits [3:0].
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low.
- ADDR  out  ADDR_W  SRAM address.
- Data_Mem_Out  out  16  write data toward the external tristate.
- Data_Mem_In  in  16  read data from the external tristate.
- mem_drive  out  1  tristate enable; 1 = FPGA drives the SRAM data bus.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE with cpu_req = 1: latch cpu_we, cpu_be, cpu_addr and cpu_wdata. Inputs are ignored in every other state.
- IO access (latched addr == IO_ADDR):
  - Go IDLE -> DONE; no SRAM strobe asserts.
  - Read: cpu_rdata <= Switches, sampled on the IDLE edge.
  - Write: hex_digits <= cpu_wdata[4*NUM_HEX-1:0]. If NUM_HEX > 4, the upper digits load 0.
  - cpu_be is ignored for IO.
- SRAM read: IDLE -> ACCESS.
  - In ACCESS: CE = 0, OE = 0, UB = 0, LB = 0; ADDR = latched address.
  - Wait counter loads WAIT_STATES on entry and decrements each cycle.
  - When counter == 0: capture Data_Mem_In into cpu_rdata and go to DONE.
- SRAM write: IDLE -> SETUP -> ACCESS.
  - SETUP: CE = 0, WE = 1, ADDR stable, Data_Mem_Out = wdata, mem_drive = 1.
  - ACCESS: WE = 0, UB = ~be[1], LB = ~be[0]; counter behaves as in a read.
  - Then DONE: WE = 1, CE = 0, data and address held, mem_drive = 1 (hold time).
  - be = 00 still runs the full sequence with UB = LB = 1, so no byte is written.
- DONE: cpu_ready = 1 for exactly one cycle, then unconditionally return to IDLE.
- Strobes outside the cases above: CE, OE, WE, UB, LB = 1 and mem_drive = 0.
- Outputs are registered from state, so there is no combinational path from cpu_* inputs to the SRAM pins.
- Reset values, applied asynchronously:
  - State IDLE; CE, OE, WE, UB, LB = 1; mem_drive = 0.
  - ADDR = 0, Data_Mem_Out = 0, cpu_rdata = 0, cpu_ready = 0, hex_digits = 0, wait counter = 0.
- Reset asserted mid-operation:
  - All strobes deassert immediately.
  - The pending access is dropped and no cpu_ready is issued.
  - hex_digits is cleared.

## Timing
- Cycle 0 is the edge on which IDLE samples cpu_req = 1.
- Latency to the cpu_ready edge (W = WAIT_STATES):
  - IO access: 1.
  - SRAM read: W + 2.
  - SRAM write: W + 3.
- Strobe widths:
  - Read: OE low for W + 1 cycles.
  - Write: WE low for W + 1 cycles.
  - Write: address and data stable 1 cycle before WE falls and 1 cycle after WE rises.
- Back-to-back: if cpu_req is still 1 the cycle after DONE, the next access is sampled then. Minimum spacing between ready pulses is 2 cycles for IO.
- cpu_rdata is updated only on a read completion. Writes leave it unchanged.

## Test plan
- Reset: assert Reset asynchronously between edges -> all outputs hold their reset values immediately. Release Reset, hold cpu_req = 0 for 5 cycles -> no strobe toggles.
- SRAM read, W = 2: addr 0x00123, Data_Mem_In = 0xBEEF -> CE/OE low for cycles 1-3, UB = LB = 0; cpu_ready at cycle 4 with cpu_rdata = 0xBEEF.
- SRAM write, W = 2: addr 0x00040, wdata 0x5A5A, be = 01 -> SETUP at cycle 1 with mem_drive = 1; WE low cycles 2-4 with LB = 0, UB = 1; WE high in DONE; cpu_ready at cycle 5.
- IO: read IO_ADDR with Switches = 0x1234 -> cpu_ready at cycle 1, cpu_rdata = 0x1234, CE stays 1. Write 0xABCD to IO_ADDR -> hex_digits = 0xABCD, no SRAM strobes.
- Reset mid-write: assert Reset while WE = 0 -> WE, CE and mem_drive return to 1 at once; no cpu_ready; hex_digits = 0.
- Back-to-back with cpu_req held high: alternating IO read and SRAM read with W = 0 -> ready pulses at cycles 1, 4, 6, and so on; no request is dropped or duplicated.

Source files
------------

// File: rtl/sram_io_bridge.sv
// sram_io_bridge
//   Bridge between the SLC-3 CPU's MAR/MDR side and an external asynchronous
//   1Mx16 SRAM. It also decodes one memory-mapped IO address: reads return the
//   board switches and writes load the hex-digit display register.
//
//   Each access is a short state machine (IDLE -> [SETUP] -> ACCESS -> DONE).
//   It has a programmable number of wait states. A one-cycle cpu_ready pulse
//   lets the control unit stall on slow memory.
//
// Parameters
//   ADDR_W       SRAM / CPU address width
//   WAIT_STATES  extra cycles each SRAM strobe is held (0..15)
//   NUM_HEX      number of 4-bit display digits (1..8)
//   IO_ADDR      memory-mapped IO address
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   cpu_req/we/be       request, write select, byte enables ([1] upper, [0] lower)
//   cpu_addr/wdata      access address and write data
//   cpu_rdata/ready     read data (held) and one-cycle completion pulse
//   Switches            board switches, returned on IO reads
//   hex_digits          display register; digit 0 is bits [3:0]
//   CE/OE/WE/UB/LB      active-low SRAM strobes
//   ADDR                SRAM address
//   Data_Mem_Out/In     SRAM data toward / from the external tristate
//   mem_drive           1 = FPGA drives the SRAM data bus
module sram_io_bridge #(
  parameter int ADDR_W = 20,
  parameter int WAIT_STATES = 1,
  parameter int NUM_HEX = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR = 20'h0FFFF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_be,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [15:0]          cpu_wdata,
  output logic [15:0]          cpu_rdata,
  output logic                 cpu_ready,
  input  logic [15:0]          Switches,
  output logic [4*NUM_HEX-1:0] hex_digits,
  output logic                 CE,
  output logic                 OE,
  output logic                 WE,
  output logic                 UB,
  output logic                 LB,
  output logic [ADDR_W-1:0]    ADDR,
  output logic [15:0]          Data_Mem_Out,
  input  logic [15:0]          Data_Mem_In,
  output logic                 mem_drive
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       we_q;
  logic [1:0] be_q;

  // The display register takes the low digits of the write data. Digits
  // beyond the 16-bit data word (NUM_HEX > 4) are loaded with zero.
  function automatic logic [HEX_W-1:0] hex_load(input logic [15:0] wdata);
    logic [31:0] ext;
    ext = {16'h0000, wdata};
    return ext[HEX_W-1:0];
  endfunction

  // Every output is a flop. It is loaded with the value that belongs to the
  // state being entered. The SRAM pins therefore change together with the
  // state, and no cpu_* input reaches them combinationally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      CE           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      mem_drive    <= 1'b0;
      ADDR         <= '0;
      Data_Mem_Out <= 16'h0000;
      cpu_rdata    <= 16'h0000;
      cpu_ready    <= 1'b0;
      hex_digits   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_req) begin
            we_q <= cpu_we;
            be_q <= cpu_be;
            if (cpu_addr == IO_ADDR) begin
              // IO completes straight away; the SRAM pins stay idle.
              state     <= DONE;
              cpu_ready <= 1'b1;
              if (cpu_we) begin
                hex_digits <= hex_load(cpu_wdata);
              end else begin
                cpu_rdata <= Switches;
              end
            end else if (cpu_we) begin
              // The setup cycle puts the address and data on the bus
              // before WE falls.
              state        <= SETUP;
              ADDR         <= cpu_addr;
              Data_Mem_Out <= cpu_wdata;
              CE           <= 1'b0;
              WE           <= 1'b1;
              mem_drive    <= 1'b1;
            end else begin
              state    <= ACCESS;
              ADDR     <= cpu_addr;
              CE       <= 1'b0;
              OE       <= 1'b0;
              UB       <= 1'b0;
              LB       <= 1'b0;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        SETUP: begin
          state    <= ACCESS;
          WE       <= 1'b0;
          UB       <= ~be_q[1];
          LB       <= ~be_q[0];
          wait_cnt <= WAIT_INIT;
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= DONE;
            cpu_ready <= 1'b1;
            OE        <= 1'b1;
            WE        <= 1'b1;
            UB        <= 1'b1;
            LB        <= 1'b1;
            if (!we_q) begin
              CE        <= 1'b1;
              cpu_rdata <= Data_Mem_In;
            end
            // On a write, CE, mem_drive, ADDR and data are held one more
            // cycle after WE rises, to meet the SRAM hold time.
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        DONE: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
          CE        <= 1'b1;
          OE        <= 1'b1;
          WE        <= 1'b1;
          UB        <= 1'b1;
          LB        <= 1'b1;
          mem_drive <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_io_bridge.sv
module tb_sram_io_bridge;

  localparam int W = 2;
  localparam logic [19:0] IO_A = 20'h0FFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata, Switches;
  logic [15:0] Data_Mem_In, Data_Mem_In0;

  logic [15:0] cpu_rdata, Data_Mem_Out;
  logic        cpu_ready, CE, OE, WE, UB, LB, mem_drive;
  logic [15:0] hex_digits;
  logic [19:0] ADDR;

  logic [15:0] cpu_rdata0, Data_Mem_Out0;
  logic        cpu_ready0, CE0, OE0, WE0, UB0, LB0, mem_drive0;
  logic [23:0] hex0;
  logic [19:0] ADDR0;

  always #5 Clk = ~Clk;

  sram_io_bridge #(.ADDR_W(20), .WAIT_STATES(W), .NUM_HEX(4), .IO_ADDR(IO_A)) dut (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .Switches(Switches), .hex_digits(hex_digits),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR),
    .Data_Mem_Out(Data_Mem_Out), .Data_Mem_In(Data_Mem_In), .mem_drive(mem_drive));

  sram_io_bridge #(.ADDR_W(20), .WAIT_STATES(0), .NUM_HEX(6), .IO_ADDR(IO_A)) dut0 (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0),
    .cpu_ready(cpu_ready0), .Switches(Switches), .hex_digits(hex0),
    .CE(CE0), .OE(OE0), .WE(WE0), .UB(UB0), .LB(LB0), .ADDR(ADDR0),
    .Data_Mem_Out(Data_Mem_Out0), .Data_Mem_In(Data_Mem_In0), .mem_drive(mem_drive0));

  // Pin-level SRAM: 8 words at bench-chosen addresses, or a forced value.
  logic        use_mem, mem_load;
  logic [15:0] din_force;
  logic [19:0] maddr [8];
  logic [15:0] mseed [8];
  logic [15:0] mpin  [8];

  always_comb begin
    Data_Mem_In = 16'hDEAD;
    if (!CE && !OE) begin
      if (!use_mem) Data_Mem_In = din_force;
      else for (int i = 0; i < 8; i++) if (ADDR == maddr[i]) Data_Mem_In = mpin[i];
    end
  end

  always_comb Data_Mem_In0 = (!CE0 && !OE0) ? din_force : 16'hDEAD;

  always @(posedge Clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mpin[i] <= mseed[i];
    end else if (!CE && !WE && mem_drive) begin
      for (int i = 0; i < 8; i++) if (ADDR == maddr[i]) begin
        if (!UB) mpin[i][15:8] <= Data_Mem_Out[15:8];
        if (!LB) mpin[i][7:0]  <= Data_Mem_Out[7:0];
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int lat; int ce; int oe; int wel; int ub; int lb; int drv;
    int bad_addr; int bad_data; int post_bad;
    logic [15:0] rdata; logic [15:0] hex;
  } res_t;

  typedef struct {
    logic we; logic [1:0] be; logic [19:0] addr;
    logic [15:0] wdata; logic [15:0] din; logic [15:0] sw;
    int lat; int ce; int oe; int wel; int ub; int lb; int drv;
    logic [15:0] rdata; logic [15:0] hex;
  } vec_t;

  // One transaction on the W=2 instance. Cycle 1 is the cycle after the
  // edge that samples the request.
  task automatic run_txn(input logic we, input logic [1:0] be, input logic [19:0] addr,
                         input logic [15:0] wdata, input logic [15:0] sw, output res_t r);
    r = '{default: 0};
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata; Switches = sw;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      if (!CE) r.ce++;
      if (!OE) r.oe++;
      if (!WE) r.wel++;
      if (!UB) r.ub++;
      if (!LB) r.lb++;
      if (mem_drive) r.drv++;
      if (!CE && ADDR !== addr) r.bad_addr++;
      if (mem_drive && Data_Mem_Out !== wdata) r.bad_data++;
      if (c == 1) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_be = 2'($urandom);
        cpu_addr = 20'($urandom); cpu_wdata = 16'($urandom); Switches = 16'($urandom);
      end
      if (cpu_ready) begin
        r.lat = c;
        r.rdata = cpu_rdata;
        break;
      end
    end
    @(posedge Clk); #1;
    if (cpu_ready || !CE || !OE || !WE || mem_drive) r.post_bad = 1;
    r.hex = hex_digits;
  endtask

  task automatic check_res(input string p, input res_t r, input vec_t e);
    check({p, "_lat"},   r.lat, e.lat);
    check({p, "_ce"},    r.ce, e.ce);
    check({p, "_oe"},    r.oe, e.oe);
    check({p, "_we"},    r.wel, e.wel);
    check({p, "_ub"},    r.ub, e.ub);
    check({p, "_lb"},    r.lb, e.lb);
    check({p, "_drv"},   r.drv, e.drv);
    check({p, "_rdata"}, 32'(r.rdata), 32'(e.rdata));
    check({p, "_hex"},   32'(r.hex), 32'(e.hex));
    check({p, "_addr_stable"}, r.bad_addr, 0);
    check({p, "_data_stable"}, r.bad_data, 0);
    check({p, "_post_idle"},   r.post_bad, 0);
  endtask

  task automatic check_reset(input string p);
    check({p, "_strobes"},  32'({CE, OE, WE, UB, LB, mem_drive}), 32'h3E);
    check({p, "_ready"},    32'(cpu_ready), 0);
    check({p, "_addr"},     32'(ADDR), 0);
    check({p, "_dout"},     32'(Data_Mem_Out), 0);
    check({p, "_rdata"},    32'(cpu_rdata), 0);
    check({p, "_hex"},      32'(hex_digits), 0);
    check({p, "_strobes0"}, 32'({CE0, OE0, WE0, UB0, LB0, mem_drive0, cpu_ready0}), 32'h7C);
    check({p, "_data0"},    32'({ADDR0, Data_Mem_Out0}) | 32'(cpu_rdata0) | 32'(hex0), 0);
  endtask

  vec_t vecs[8];
  res_t r;
  vec_t e;
  logic [15:0] ref_mem[8];
  logic [15:0] ref_rd, ref_hex;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet, found, cnt_rdy, cnt_ce;
    int pc[8];
    logic [15:0] prd[8];
    logic [15:0] exp_rd[6];
    int k;

    Reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0;
    cpu_wdata = '0; Switches = '0; use_mem = 1'b0; mem_load = 1'b0; din_force = '0;
    for (int i = 0; i < 8; i++) begin maddr[i] = '0; mseed[i] = '0; end

    vecs[0] = '{we:1'b0, be:2'b11, addr:20'h00123, wdata:16'h0000, din:16'hBEEF, sw:16'h0000,
                lat:4, ce:3, oe:3, wel:0, ub:3, lb:3, drv:0, rdata:16'hBEEF, hex:16'h0000};
    vecs[1] = '{we:1'b1, be:2'b01, addr:20'h00040, wdata:16'h5A5A, din:16'h0000, sw:16'h0000,
                lat:5, ce:5, oe:0, wel:3, ub:0, lb:3, drv:5, rdata:16'hBEEF, hex:16'h0000};
    vecs[2] = '{we:1'b0, be:2'b00, addr:IO_A, wdata:16'h0000, din:16'h0000, sw:16'h1234,
                lat:1, ce:0, oe:0, wel:0, ub:0, lb:0, drv:0, rdata:16'h1234, hex:16'h0000};
    vecs[3] = '{we:1'b1, be:2'b00, addr:IO_A, wdata:16'hABCD, din:16'h0000, sw:16'h9999,
                lat:1, ce:0, oe:0, wel:0, ub:0, lb:0, drv:0, rdata:16'h1234, hex:16'hABCD};
    vecs[4] = '{we:1'b1, be:2'b00, addr:20'h00041, wdata:16'h1111, din:16'h0000, sw:16'h0000,
                lat:5, ce:5, oe:0, wel:3, ub:0, lb:0, drv:5, rdata:16'h1234, hex:16'hABCD};
    vecs[5] = '{we:1'b1, be:2'b11, addr:20'h0FFFE, wdata:16'h2222, din:16'h0000, sw:16'h0000,
                lat:5, ce:5, oe:0, wel:3, ub:3, lb:3, drv:5, rdata:16'h1234, hex:16'hABCD};
    vecs[6] = '{we:1'b0, be:2'b01, addr:20'h0FFFE, wdata:16'h0000, din:16'h0F0F, sw:16'h0000,
                lat:4, ce:3, oe:3, wel:0, ub:3, lb:3, drv:0, rdata:16'h0F0F, hex:16'hABCD};
    vecs[7] = '{we:1'b0, be:2'b10, addr:20'hFFFFF, wdata:16'h0000, din:16'h8001, sw:16'h0000,
                lat:4, ce:3, oe:3, wel:0, ub:3, lb:3, drv:0, rdata:16'h8001, hex:16'hABCD};

    // Reset asserted between clock edges
    #1 Reset = 1'b1;
    #2 check_reset("reset");
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      if ({CE, OE, WE, UB, LB, mem_drive, cpu_ready} !== 7'b1111100) quiet++;
    end
    check("idle_no_toggle", quiet, 0);

    // Directed vectors on the W=2 instance
    for (int i = 0; i < 8; i++) begin
      din_force = vecs[i].din;
      run_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].sw, r);
      check_res($sformatf("vec%0d", i), r, vecs[i]);
    end
    check("hex6_zero_fill", 32'(hex0), 32'h00ABCD);

    // Reset in the middle of a write, while WE is low
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 20'h00200; cpu_wdata = 16'hC3C3;
    @(posedge Clk); #1;
    cpu_req = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (!WE) found = 1;
      else begin @(posedge Clk); #1; end
    end
    check("midwr_we_low_seen", found, 1);
    #2 Reset = 1'b1;
    #1 check_reset("midwr");
    @(posedge Clk); #1 Reset = 1'b0;
    cnt_rdy = 0; cnt_ce = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk); #1;
      if (cpu_ready) cnt_rdy++;
      if (!CE) cnt_ce++;
    end
    check("midwr_no_ready", cnt_rdy, 0);
    check("midwr_no_strobe", cnt_ce, 0);

    // Randomized transactions against a word-level memory model
    for (int i = 0; i < 8; i++) begin
      maddr[i] = {16'($urandom), 4'(i)};
      if (maddr[i] == IO_A) maddr[i][19] = 1'b1;
      mseed[i] = 16'($urandom);
      ref_mem[i] = mseed[i];
    end
    mem_load = 1'b1; use_mem = 1'b1;
    @(posedge Clk); #1 mem_load = 1'b0;
    ref_rd = 16'h0000; ref_hex = 16'h0000;
    for (int t = 0; t < 40; t++) begin
      int sel;
      logic io;
      logic [19:0] a;
      sel = int'($urandom_range(0, 9));
      io = (sel >= 8);
      a = io ? IO_A : maddr[sel];
      e.we = 1'($urandom); e.be = 2'($urandom); e.wdata = 16'($urandom); e.sw = 16'($urandom);
      e.lat = io ? 1 : (e.we ? W + 3 : W + 2);
      e.ce  = io ? 0 : (e.we ? W + 3 : W + 1);
      e.oe  = (!io && !e.we) ? W + 1 : 0;
      e.wel = (!io && e.we) ? W + 1 : 0;
      e.drv = (!io && e.we) ? W + 3 : 0;
      e.ub  = io ? 0 : ((!e.we || e.be[1]) ? W + 1 : 0);
      e.lb  = io ? 0 : ((!e.we || e.be[0]) ? W + 1 : 0);
      if (io && e.we) ref_hex = e.wdata;
      else if (io) ref_rd = e.sw;
      else if (!e.we) ref_rd = ref_mem[sel];
      else begin
        if (e.be[1]) ref_mem[sel][15:8] = e.wdata[15:8];
        if (e.be[0]) ref_mem[sel][7:0]  = e.wdata[7:0];
      end
      e.rdata = ref_rd; e.hex = ref_hex;
      run_txn(e.we, e.be, a, e.wdata, e.sw, r);
      check_res($sformatf("rnd%0d", t), r, e);
    end

    // Back-to-back on the W=0 instance: IO read / SRAM read alternating
    use_mem = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin pc[i] = 0; prd[i] = '0; end
    for (int i = 0; i < 6; i++) exp_rd[i] = (i % 2 == 0) ? 16'(16'h1000 + i) : 16'(16'h2000 + i);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11;
    cpu_addr = IO_A; Switches = 16'h1000; din_force = 16'hDEAD;
    for (int c = 1; c <= 15; c++) begin
      @(posedge Clk); #1;
      if (cpu_ready0) begin
        if (k < 8) begin pc[k] = c; prd[k] = cpu_rdata0; end
        k++;
        if (k % 2 == 0) begin
          cpu_addr = IO_A; Switches = 16'(16'h1000 + k);
        end else begin
          cpu_addr = 20'(20'h00100 + k); din_force = 16'(16'h2000 + k);
        end
      end
      if (c == 15) cpu_req = 1'b0;
    end
    check("b2b_pulse_count", k, 6);
    check("b2b_cyc0", pc[0], 1);
    check("b2b_cyc1", pc[1], 4);
    check("b2b_cyc2", pc[2], 6);
    check("b2b_cyc3", pc[3], 9);
    check("b2b_cyc4", pc[4], 11);
    check("b2b_cyc5", pc[5], 14);
    for (int i = 0; i < 6; i++) check($sformatf("b2b_rdata%0d", i), 32'(prd[i]), 32'(exp_rd[i]));
    repeat (6) @(posedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
